// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB register: LDUR/STUR over a req/ack data port, branch redirect, writeback bundle.
// Latency: non-memory ops reach WB one edge later; memory ops reach WB on the edge after dmem_ack.
// Backpressure: stall holds upstream from the issue cycle until the ack (or timeout) cycle.
module mem_wb_stage #(
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned ADDR_ALIGN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [63:0] mem_aluout,
  input  logic [63:0] mem_busB,
  input  logic [4:0]  mem_rd,
  input  logic        mem_mem2reg,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        mem_branch,
  input  logic        mem_uncond_branch,
  input  logic        mem_zero,
  input  logic [63:0] mem_branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        mem_error
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  logic [0:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [63:0] wb_data_q, wb_data_d;

  logic memop, misaligned, start, in_wait, timeout;

  assign memop      = mem_valid & (mem_memread | mem_memwrite);
  assign misaligned = memop & (mem_aluout[ADDR_ALIGN-1:0] != '0);
  assign start      = (state_q == S_IDLE) & memop & ~misaligned;
  assign in_wait    = (state_q == S_WAIT);
  // Timeout only counts when no ack arrives that cycle: a late ack still completes normally.
  assign timeout    = in_wait & ~dmem_ack & (cnt_q == LAST_CNT);

  assign stall         = start | (in_wait & ~dmem_ack & ~timeout);
  assign pcsrc         = mem_valid & (mem_uncond_branch | (mem_branch & mem_zero));
  assign branch_target = mem_branch_target;

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign mem_error   = err_q;

  // Access FSM: latch the request on issue, hold it stable until ack or timeout.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_WAIT;
        req_d   = 1'b1;
        we_d    = mem_memwrite;
        addr_d  = mem_aluout;
        wdata_d = mem_busB;
        cnt_d   = 8'd0;
      end
    end else begin
      if (dmem_ack || timeout) begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    err_d = err_q | misaligned | timeout;
  end

  // MEM/WB next value: bubble while stalled, otherwise retire the EX/MEM slot.
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    if (!stall) begin
      wb_valid_d    = mem_valid;
      wb_rd_d       = mem_rd;
      wb_data_d     = mem_mem2reg ? dmem_rdata : mem_aluout;
      wb_regwrite_d = mem_valid & mem_regwrite & ~misaligned & ~(timeout & mem_memread);
    end
  end

  // State and pipeline registers; reset also abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (MAX_WAIT=4): ALU op, load, store, misaligned, timeout, branch, reset.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_mem2reg, mem_regwrite, mem_memread, mem_memwrite;
  logic        mem_branch, mem_uncond_branch, mem_zero;
  logic [63:0] mem_aluout, mem_busB, mem_branch_target;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pcsrc, wb_valid, wb_regwrite, mem_error;
  logic [63:0] branch_target, wb_data;
  logic [4:0]  wb_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.MAX_WAIT(4), .ADDR_ALIGN(3)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_aluout(mem_aluout), .mem_busB(mem_busB), .mem_rd(mem_rd),
    .mem_mem2reg(mem_mem2reg), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_branch(mem_branch), .mem_uncond_branch(mem_uncond_branch),
    .mem_zero(mem_zero), .mem_branch_target(mem_branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    mem_valid = 0; mem_aluout = 0; mem_busB = 0; mem_rd = 0; mem_mem2reg = 0;
    mem_regwrite = 0; mem_memread = 0; mem_memwrite = 0; mem_branch = 0;
    mem_uncond_branch = 0; mem_zero = 0; mem_branch_target = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [4:0] rd);
    clr_in();
    mem_valid = 1; mem_memread = 1; mem_mem2reg = 1; mem_regwrite = 1;
    mem_aluout = a; mem_rd = rd;
  endtask

  initial begin
    clr_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err", mem_error, 0);
    chk("rst_stall", stall, 0);

    // ALU op
    mem_valid = 1; mem_aluout = 64'h1234; mem_rd = 5; mem_regwrite = 1;
    #1 chk("add_stall", stall, 0);
    tick();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_rd", wb_rd, 5);
    chk("add_wb_data", wb_data, 64'h1234);
    chk("add_wb_regwrite", wb_regwrite, 1);

    // Load with ack two cycles after request rises
    load(64'h100, 5'd7);
    #1 chk("ld_stall0", stall, 1);
    tick();
    chk("ld_req", dmem_req, 1);
    chk("ld_addr", dmem_addr, 64'h100);
    chk("ld_we", dmem_we, 0);
    chk("ld_bubble1", wb_valid, 0);
    chk("ld_stall1", stall, 1);
    tick();
    chk("ld_bubble2", wb_valid, 0);
    chk("ld_stall2", stall, 1);
    tick();
    dmem_ack = 1; dmem_rdata = 64'hDEADBEEF;
    #1 chk("ld_stall_ack", stall, 0);
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 64'hDEADBEEF);
    chk("ld_wb_regwrite", wb_regwrite, 1);
    chk("ld_wb_rd", wb_rd, 7);
    chk("ld_req_drop", dmem_req, 0);

    // Store
    clr_in();
    mem_valid = 1; mem_memwrite = 1; mem_aluout = 64'h208; mem_busB = 64'h55; mem_rd = 9;
    tick();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 64'h55);
    tick();
    chk("st_wdata_hold", dmem_wdata, 64'h55);
    chk("st_addr_hold", dmem_addr, 64'h208);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_regwrite", wb_regwrite, 0);
    chk("st_req_drop", dmem_req, 0);

    // Misaligned load
    load(64'h104, 5'd4);
    #1 chk("mis_stall", stall, 0);
    tick();
    chk("mis_req", dmem_req, 0);
    chk("mis_err", mem_error, 1);
    chk("mis_wb_regwrite", wb_regwrite, 0);
    chk("mis_wb_valid", wb_valid, 1);
    clr_in();
    mem_valid = 1; mem_aluout = 64'h10; mem_rd = 2; mem_regwrite = 1;
    tick();
    chk("mis_err_sticky", mem_error, 1);
    chk("after_mis_regwrite", wb_regwrite, 1);

    // Reset clears the sticky error
    clr_in();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_err_clr", mem_error, 0);

    // Timeout: ack never arrives, request held MAX_WAIT cycles
    load(64'h300, 5'd6);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), dmem_req, 1);
      chk($sformatf("to_stall%0d", i), stall, (i < 3) ? 1 : 0);
      chk($sformatf("to_err%0d", i), mem_error, 0);
      tick();
    end
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", mem_error, 1);
    chk("to_wb_regwrite", wb_regwrite, 0);
    chk("to_wb_valid", wb_valid, 1);

    // Branches
    clr_in();
    mem_valid = 1; mem_branch = 1; mem_zero = 1; mem_branch_target = 64'h40;
    mem_aluout = 64'h77; mem_rd = 3;
    #1 chk("cbz_taken", pcsrc, 1);
    chk("cbz_target", branch_target, 64'h40);
    chk("cbz_stall", stall, 0);
    mem_zero = 0;
    #1 chk("cbz_not_taken", pcsrc, 0);
    mem_branch = 0; mem_uncond_branch = 1;
    #1 chk("b_taken", pcsrc, 1);
    mem_valid = 0;
    #1 chk("b_invalid", pcsrc, 0);
    mem_valid = 1;
    tick();
    chk("b_wb_data", wb_data, 64'h77);

    // Reset mid-WAIT
    load(64'h400, 5'd8);
    tick();
    chk("rw_req", dmem_req, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    clr_in();
    chk("rw_req0", dmem_req, 0);
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_wb_regwrite", wb_regwrite, 0);
    chk("rw_wb_rd", wb_rd, 0);
    chk("rw_wb_data", wb_data, 0);
    dmem_ack = 1; dmem_rdata = 64'hBAD;
    #1 chk("rw_stall", stall, 0);
    tick();
    dmem_ack = 0;
    chk("rw_late_ack_req", dmem_req, 0);
    chk("rw_late_ack_valid", wb_valid, 0);
    chk("rw_late_ack_err", mem_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
